// File: rtl/shift_register_universal.sv
// Parametrised universal shift register: single-step modes plus an autonomous
// multi-step burst engine reporting busy/done.
module shift_register_universal #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] data_in,
  input  logic             ser_in_l,
  input  logic             ser_in_r,
  input  logic             start,
  input  logic [CNT_W-1:0] count,
  output logic [WIDTH-1:0] data_out,
  output logic             ser_out_l,
  output logic             ser_out_r,
  output logic             busy,
  output logic             done
);

  typedef enum logic [2:0] {
    M_HOLD  = 3'b000,
    M_LOAD  = 3'b001,
    M_SHL   = 3'b010,
    M_SHR   = 3'b011,
    M_ROL   = 3'b100,
    M_ROR   = 3'b101,
    M_ASR   = 3'b110,
    M_CLEAR = 3'b111
  } mode_t;

  typedef enum logic {
    IDLE,
    BURST
  } state_t;

  state_t           state;
  logic [2:0]       burst_mode;
  logic [CNT_W-1:0] remaining;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] step_live;
  logic [WIDTH-1:0] step_burst;
  logic             burst_req;

  function automatic logic [WIDTH-1:0] step(
    input logic [2:0]       md,
    input logic [WIDTH-1:0] cur,
    input logic [WIDTH-1:0] load_val,
    input logic             sl,
    input logic             sr
  );
    logic [WIDTH-1:0] r;
    r = cur;
    case (mode_t'(md))
      M_HOLD:  r = cur;
      M_LOAD:  r = load_val;
      M_SHL:   r = {cur[WIDTH-2:0], sr};
      M_SHR:   r = {sl, cur[WIDTH-1:1]};
      M_ROL:   r = {cur[WIDTH-2:0], cur[WIDTH-1]};
      M_ROR:   r = {cur[0], cur[WIDTH-1:1]};
      M_ASR:   r = {cur[WIDTH-1], cur[WIDTH-1:1]};
      M_CLEAR: r = '0;
      default: r = cur;
    endcase
    return r;
  endfunction

  // Shift-class modes are the contiguous range 010..110.
  always_comb begin
    burst_req  = start && (mode >= 3'b010) && (mode <= 3'b110) && (count != '0);
    step_live  = step(mode, q, data_in, ser_in_l, ser_in_r);
    step_burst = step(burst_mode, q, data_in, ser_in_l, ser_in_r);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      q          <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      remaining  <= '0;
      burst_mode <= 3'b000;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (burst_req) begin
            burst_mode <= mode;
            remaining  <= count;
            busy       <= 1'b1;
            state      <= BURST;
          end else begin
            q <= step_live;
          end
        end
        BURST: begin
          q         <= step_burst;
          remaining <= remaining - 1'b1;
          if (remaining == CNT_W'(1)) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign data_out  = q;
  assign ser_out_l = q[WIDTH-1];
  assign ser_out_r = q[0];

endmodule

// File: tb/tb_shift_register_universal.sv
// Directed plus randomized bench; a queue of pending burst steps models the
// burst engine, and each step is computed with plain integer arithmetic.
module tb_shift_register_universal;
  localparam int unsigned W = 8;
  localparam int unsigned C = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic [2:0]   mode;
  logic [W-1:0] data_in;
  logic         ser_in_l;
  logic         ser_in_r;
  logic         start;
  logic [C-1:0] count;
  logic [W-1:0] data_out;
  logic         ser_out_l;
  logic         ser_out_r;
  logic         busy;
  logic         done;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] m_q;
  logic         m_done;
  logic [2:0]   pend[$];

  shift_register_universal #(.WIDTH(W), .CNT_W(C)) dut (
    .clk(clk), .reset(reset), .mode(mode), .data_in(data_in),
    .ser_in_l(ser_in_l), .ser_in_r(ser_in_r), .start(start), .count(count),
    .data_out(data_out), .ser_out_l(ser_out_l), .ser_out_r(ser_out_r),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] ref_step(input logic [2:0] md, input logic [W-1:0] q,
                                            input logic [W-1:0] di, input logic sl, input logic sr);
    int unsigned v;
    int unsigned top;
    v   = int'(q);
    top = 1 << (W - 1);
    case (md)
      3'd0: return q;
      3'd1: return di;
      3'd2: return W'(v * 2 + int'(sr));
      3'd3: return W'(v / 2 + (sl ? top : 0));
      3'd4: return W'(v * 2 + v / top);
      3'd5: return W'(v / 2 + (v % 2) * top);
      3'd6: return W'(v / 2 + ((v >= top) ? top : 0));
      default: return '0;
    endcase
  endfunction

  task automatic model_edge();
    logic [2:0] md;
    if (pend.size() != 0) begin
      md     = pend.pop_front();
      m_q    = ref_step(md, m_q, data_in, ser_in_l, ser_in_r);
      m_done = (pend.size() == 0);
    end else begin
      m_done = 1'b0;
      if (start && mode >= 3'd2 && mode <= 3'd6 && count != 0)
        for (int i = 0; i < int'(count); i++) pend.push_back(mode);
      else
        m_q = ref_step(mode, m_q, data_in, ser_in_l, ser_in_r);
    end
  endtask

  task automatic check_all();
    chk("data_out", data_out, m_q);
    chk("ser_out_l", ser_out_l, m_q[W-1]);
    chk("ser_out_r", ser_out_r, m_q[0]);
    chk("busy", busy, pend.size() != 0);
    chk("done", done, m_done);
  endtask

  task automatic cycle();
    model_edge();
    @(posedge clk);
    #1 check_all();
  endtask

  // Asynchronous reset pulsed between edges; outputs must clear immediately.
  task automatic do_reset();
    reset = 1'b1;
    m_q = '0;
    m_done = 1'b0;
    pend.delete();
    #2 check_all();
    reset = 1'b0;
  endtask

  task automatic drive(input logic [2:0] md, input logic [W-1:0] di, input logic st,
                       input logic [C-1:0] cn, input logic sl, input logic sr);
    mode = md; data_in = di; start = st; count = cn; ser_in_l = sl; ser_in_r = sr;
  endtask

  initial begin
    drive(3'd0, '0, 1'b0, '0, 1'b0, 1'b0);
    do_reset();

    drive(3'd1, 8'hAA, 0, 0, 0, 0); cycle();
    drive(3'd0, 8'h00, 0, 0, 0, 0);
    repeat (3) cycle();
    chk("hold_aa", data_out, 8'hAA);
    drive(3'd2, 8'h00, 0, 0, 0, 1); cycle();
    chk("shl_55", data_out, 8'h55);
    chk("shl_ser_r", ser_out_r, 1'b1);
    drive(3'd3, 8'h00, 0, 0, 0, 0); cycle();
    chk("shr_2a", data_out, 8'h2A);
    drive(3'd7, 8'h00, 0, 0, 0, 0); cycle();
    chk("clear", data_out, 8'h00);

    drive(3'd1, 8'h80, 0, 0, 0, 0); cycle();
    drive(3'd6, 8'h00, 0, 0, 0, 0);
    cycle(); chk("asr_c0", data_out, 8'hC0);
    cycle(); chk("asr_e0", data_out, 8'hE0);
    cycle(); chk("asr_f0", data_out, 8'hF0);
    drive(3'd1, 8'h01, 0, 0, 0, 0); cycle();
    drive(3'd5, 8'h00, 0, 0, 0, 0); cycle();
    chk("ror_80", data_out, 8'h80);
    chk("ror_ser_l", ser_out_l, 1'b1);

    drive(3'd1, 8'h81, 0, 0, 0, 0); cycle();
    drive(3'd4, 8'h00, 1, 4'd3, 0, 0); cycle();
    chk("burst_start_busy", busy, 1'b1);
    chk("burst_start_hold", data_out, 8'h81);
    drive(3'd1, 8'hFF, 1, 4'd7, 0, 0); cycle(); chk("burst_s1", data_out, 8'h03);
    drive(3'd7, 8'h5A, 0, 4'd1, 1, 1); cycle(); chk("burst_s2", data_out, 8'h06);
    drive(3'd0, 8'h00, 0, 4'd0, 0, 0); cycle(); chk("burst_s3", data_out, 8'h0C);
    chk("burst_done", done, 1'b1);
    chk("burst_idle", busy, 1'b0);
    cycle(); chk("done_pulse_end", done, 1'b0);

    drive(3'd1, 8'h81, 0, 0, 0, 0); cycle();
    drive(3'd4, 8'h00, 1, 4'd9, 0, 0); cycle();
    drive(3'd0, 8'h00, 0, 0, 0, 0);
    repeat (9) cycle();
    chk("rol9_result", data_out, 8'h03);
    chk("rol9_done", done, 1'b1);

    drive(3'd1, 8'h01, 0, 0, 0, 0); cycle();
    drive(3'd2, 8'h00, 1, 4'd0, 0, 0); cycle();
    chk("cnt0_shift", data_out, 8'h02);
    chk("cnt0_busy", busy, 1'b0);

    drive(3'd1, 8'hC3, 0, 0, 0, 0); cycle();
    drive(3'd5, 8'h00, 1, 4'd10, 0, 0); cycle();
    drive(3'd0, 8'h00, 0, 0, 0, 0);
    repeat (4) cycle();
    do_reset();
    chk("mid_reset_q", data_out, 8'h00);
    chk("mid_reset_busy", busy, 1'b0);
    repeat (8) cycle();
    drive(3'd1, 8'h0F, 0, 0, 0, 0); cycle();
    drive(3'd2, 8'h00, 1, 4'd2, 0, 0); cycle();
    drive(3'd0, 8'h00, 0, 0, 0, 0);
    repeat (2) cycle();
    chk("post_reset_burst", data_out, 8'h3C);
    chk("post_reset_done", done, 1'b1);

    for (int i = 0; i < 1500; i++) begin
      drive(3'($urandom_range(0, 7)), W'($urandom), ($urandom_range(0, 3) == 0),
            C'($urandom), 1'($urandom), 1'($urandom));
      cycle();
      if ($urandom_range(0, 99) == 0) do_reset();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
